// File: rtl/booth_multiplier_n.sv
// Sequential WIDTH-bit shift-add multiplier with signed/unsigned mode.
// Product ends in X:A:B; one ADD and one SHIFT cycle per multiplier bit.
module booth_multiplier_n #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset_Load_Clear,
   input  logic             Run,
   input  logic [WIDTH-1:0] SW,
   input  logic             Signed_Mode,
   output logic [WIDTH-1:0] Aval,
   output logic [WIDTH-1:0] Bval,
   output logic             Xval,
   output logic             Busy,
   output logic             Done
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {IDLE, CLEAR, ADD, SHIFT, HOLD} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a, b, s;
   logic             x, mode, run_prev;
   logic [CW-1:0]    cnt;
   logic             start, last;
   logic [WIDTH:0]   ext_a, ext_s, sum;

   assign start = Run && !run_prev && (state == IDLE || state == HOLD);
   assign last  = (cnt == CW'(WIDTH-1));
   assign ext_a = mode ? {a[WIDTH-1], a} : {1'b0, a};
   assign ext_s = mode ? {s[WIDTH-1], s} : {1'b0, s};
   // The top multiplier bit carries negative weight in two's complement.
   assign sum   = (mode && last) ? (ext_a - ext_s) : (ext_a + ext_s);

   always_ff @(posedge Clk) begin
      if (Reset_Load_Clear) state <= IDLE;
      else                  state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, HOLD: if (start) state_nxt = CLEAR;
         CLEAR:      state_nxt = ADD;
         ADD:        state_nxt = SHIFT;
         SHIFT:      state_nxt = last ? HOLD : ADD;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset_Load_Clear) begin
         a        <= '0;
         x        <= 1'b0;
         b        <= SW;
         s        <= '0;
         mode     <= 1'b0;
         cnt      <= '0;
         // Treat Run as already high so a held Run cannot start an operation.
         run_prev <= 1'b1;
      end else begin
         run_prev <= Run;
         case (state)
            IDLE, HOLD: begin
               if (start) begin
                  s    <= SW;
                  mode <= Signed_Mode;
               end
            end
            CLEAR: begin
               a   <= '0;
               x   <= 1'b0;
               cnt <= '0;
            end
            ADD: begin
               if (b[0]) {x, a} <= sum;
            end
            SHIFT: begin
               x   <= mode ? x : 1'b0;
               a   <= {x, a[WIDTH-1:1]};
               b   <= {a[0], b[WIDTH-1:1]};
               cnt <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign Aval = a;
   assign Bval = b;
   assign Xval = x;
   assign Busy = (state == CLEAR) || (state == ADD) || (state == SHIFT);
   assign Done = (state == HOLD);
endmodule
